ser_cmd_asm: RTL and testbench

Downstream stage of the serial byte receiver (rcv). Consumes its one-byte-per-strobe output, frames bytes into GPU commands (opcode plus 0/1/2/4 argument bytes), and presents each command on a valid/ready interface to the GPU command dispatcher. Detects inter-byte timeouts and overruns, reporting them as sticky error flags.

---
 rtl/ser_pkg.sv | 29 ++
 rtl/ser_timeout.sv | 35 +++
 rtl/ser_cmd_asm.sv | 130 +++++++++++++
 tb/tb_ser_cmd_asm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared serial-link timing constants, command-assembler state type and the
// opcode-to-argument-length decode.
package ser_pkg;

   localparam int unsigned SER_CLK_HZ        = 50_000_000;
   localparam int unsigned SER_BAUD          = 10_000;
   localparam int unsigned SER_BITS_PER_BYTE = 10;  // start + 8 data + stop
   localparam int unsigned SER_CLKS_PER_BIT  = SER_CLK_HZ / SER_BAUD;
   localparam int unsigned SER_CLKS_PER_BYTE = SER_CLKS_PER_BIT * SER_BITS_PER_BYTE;
   localparam int unsigned SER_TIMER_MIN_W   = 18;

   typedef enum logic [1:0] {
      StIdle,
      StArgs,
      StHold
   } state_e;

   function automatic logic [2:0] arg_len(input logic [7:0] opcode);
      logic [2:0] len;
      unique case (opcode[7:6])
         2'b00:   len = 3'd0;
         2'b01:   len = 3'd1;
         2'b10:   len = 3'd2;
         default: len = 3'd4;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ser_timeout.sv
// Inter-byte silence counter: loadable up-counter with clear/enable that flags
// expiry when it holds TIMEOUT_CLOCKS-1.
module ser_timeout
   import ser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CLOCKS = 200_000,
   parameter int unsigned CNT_W          = ($clog2(TIMEOUT_CLOCKS) > SER_TIMER_MIN_W) ?
                                           $clog2(TIMEOUT_CLOCKS) : SER_TIMER_MIN_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = (r_count == CNT_W'(TIMEOUT_CLOCKS - 1));

endmodule

// File: rtl/ser_cmd_asm.sv
// Frames received bytes into opcode + 0/1/2/4 argument-byte commands and hands
// them to the dispatcher over valid/ready, with sticky timeout/overrun flags.
module ser_cmd_asm
   import ser_pkg::*;
#(
   parameter int unsigned CLK_HZ        = SER_CLK_HZ,
   parameter int unsigned BAUD          = SER_BAUD,
   parameter int unsigned TIMEOUT_BYTES = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rcv_full,
   input  logic [7:0]  i_rcv_data,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [7:0]  o_cmd_opcode,
   output logic [31:0] o_cmd_arg,
   output logic        o_err_timeout,
   output logic        o_err_overrun,
   input  logic        i_err_clear
);

   localparam int unsigned TIMEOUT_CLOCKS = (CLK_HZ / BAUD) * SER_BITS_PER_BYTE * TIMEOUT_BYTES;
   localparam int unsigned CNT_W          = ($clog2(TIMEOUT_CLOCKS) > SER_TIMER_MIN_W) ?
                                            $clog2(TIMEOUT_CLOCKS) : SER_TIMER_MIN_W;

   state_e      r_state, w_state_nxt;
   logic [7:0]  r_opcode, w_opcode_nxt;
   logic [31:0] r_arg, w_arg_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic        r_err_timeout, r_err_overrun;

   logic       w_take_op;
   logic       w_set_tmo;
   logic       w_set_ovr;
   logic [2:0] w_len;
   logic       w_tmr_en;
   logic       w_tmr_clr;
   logic       w_expired;

   assign w_len     = arg_len(r_opcode);
   assign w_tmr_en  = (r_state == StArgs) && !i_rcv_full;
   // Clearing on expiry keeps the counter from ever stepping past its limit.
   assign w_tmr_clr = !w_tmr_en || w_expired;

   ser_timeout #(
      .TIMEOUT_CLOCKS (TIMEOUT_CLOCKS),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_tmr_clr),
      .i_en       (w_tmr_en),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_expired  (w_expired)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_opcode_nxt = r_opcode;
      w_arg_nxt    = r_arg;
      w_idx_nxt    = r_idx;
      w_take_op    = 1'b0;
      w_set_tmo    = 1'b0;
      w_set_ovr    = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_take_op = i_rcv_full;
         end
         StArgs: begin
            if (i_rcv_full) begin
               w_arg_nxt[{r_idx, 3'b000} +: 8] = i_rcv_data;
               w_idx_nxt                       = r_idx + 2'd1;
               if (({1'b0, r_idx} + 3'd1) == w_len) begin
                  w_state_nxt = StHold;
               end
            end else if (w_expired) begin
               w_set_tmo   = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         StHold: begin
            if (i_cmd_ready) begin
               w_state_nxt = StIdle;
               w_take_op   = i_rcv_full;
            end else if (i_rcv_full) begin
               w_set_ovr = 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase

      if (w_take_op) begin
         w_opcode_nxt = i_rcv_data;
         w_arg_nxt    = '0;
         w_idx_nxt    = '0;
         w_state_nxt  = (arg_len(i_rcv_data) == 3'd0) ? StHold : StArgs;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_opcode      <= '0;
         r_arg         <= '0;
         r_idx         <= '0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_opcode      <= w_opcode_nxt;
         r_arg         <= w_arg_nxt;
         r_idx         <= w_idx_nxt;
         // A new error in the same cycle as a clear request still latches.
         r_err_timeout <= w_set_tmo | (r_err_timeout & ~i_err_clear);
         r_err_overrun <= w_set_ovr | (r_err_overrun & ~i_err_clear);
      end
   end

   assign o_cmd_valid   = (r_state == StHold);
   assign o_cmd_opcode  = r_opcode;
   assign o_cmd_arg     = r_arg;
   assign o_err_timeout = r_err_timeout;
   assign o_err_overrun = r_err_overrun;

endmodule

// File: tb/tb_ser_cmd_asm.sv
// Directed bench for ser_cmd_asm, built with a fast clock so the byte-time
// timeout is 400 clocks instead of 200000.
module tb_ser_cmd_asm;

   localparam int unsigned TB_CLK_HZ  = 100_000;
   localparam int unsigned TB_BAUD    = 10_000;
   localparam int unsigned TB_TMO_BYT = 4;
   localparam int unsigned TMO        = (TB_CLK_HZ / TB_BAUD) * 10 * TB_TMO_BYT;  // 400

   logic        clk;
   logic        reset;
   logic        rcv_full;
   logic [7:0]  rcv_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [31:0] cmd_arg;
   logic        err_timeout;
   logic        err_overrun;
   logic        err_clear;

   int n_checks;
   int n_fail;

   ser_cmd_asm #(
      .CLK_HZ        (TB_CLK_HZ),
      .BAUD          (TB_BAUD),
      .TIMEOUT_BYTES (TB_TMO_BYT)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rcv_full    (rcv_full),
      .i_rcv_data    (rcv_data),
      .o_cmd_valid   (cmd_valid),
      .i_cmd_ready   (cmd_ready),
      .o_cmd_opcode  (cmd_opcode),
      .o_cmd_arg     (cmd_arg),
      .o_err_timeout (err_timeout),
      .o_err_overrun (err_overrun),
      .i_err_clear   (err_clear)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle byte strobe; entered and left on a falling edge.
   task automatic strobe(input logic [7:0] b);
      rcv_full = 1'b1;
      rcv_data = b;
      @(negedge clk);
      rcv_full = 1'b0;
      rcv_data = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_cmd(input string tag, input logic [7:0] op, input logic [31:0] arg);
      check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd1);
      check_eq({tag, "_opcode"}, 32'(cmd_opcode), 32'(op));
      check_eq({tag, "_arg"}, cmd_arg, arg);
   endtask

   task automatic retire(input string tag);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check_eq({tag, "_retired"}, 32'(cmd_valid), 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      clk       = 1'b0;
      reset     = 1'b1;
      rcv_full  = 1'b0;
      rcv_data  = 8'h00;
      cmd_ready = 1'b0;
      err_clear = 1'b0;

      #12;
      check_eq("rst_valid", 32'(cmd_valid), 32'd0);
      check_eq("rst_opcode", 32'(cmd_opcode), 32'd0);
      check_eq("rst_arg", cmd_arg, 32'd0);
      check_eq("rst_tmo", 32'(err_timeout), 32'd0);
      check_eq("rst_ovr", 32'(err_overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // 1: zero-arg opcode, valid the edge after its strobe, for one cycle
      cmd_ready = 1'b1;
      strobe(8'h05);
      expect_cmd("t1", 8'h05, 32'h0);
      check_eq("t1_tmo", 32'(err_timeout), 32'd0);
      check_eq("t1_ovr", 32'(err_overrun), 32'd0);
      idle(1);
      check_eq("t1_one_cycle", 32'(cmd_valid), 32'd0);
      cmd_ready = 1'b0;

      // 2: four-byte argument, one gap landing exactly on the timeout cycle
      strobe(8'hC1);
      idle(100);
      strobe(8'h78);
      idle(200);
      strobe(8'h56);
      idle(TMO - 1);
      strobe(8'h34);
      idle(100);
      check_eq("t2_not_yet", 32'(cmd_valid), 32'd0);
      strobe(8'h12);
      expect_cmd("t2", 8'hC1, 32'h1234_5678);
      check_eq("t2_tmo", 32'(err_timeout), 32'd0);
      retire("t2");

      // two-byte argument fills only the low half
      strobe(8'h8F);
      strobe(8'h34);
      strobe(8'h12);
      expect_cmd("t2b", 8'h8F, 32'h0000_1234);
      retire("t2b");

      // 3: timeout after silence
      strobe(8'h81);
      strobe(8'hAA);
      idle(TMO - 1);
      check_eq("t3_tmo_early", 32'(err_timeout), 32'd0);
      idle(1);
      check_eq("t3_tmo_set", 32'(err_timeout), 32'd1);
      check_eq("t3_no_valid", 32'(cmd_valid), 32'd0);
      strobe(8'h02);
      expect_cmd("t3_next", 8'h02, 32'h0);
      retire("t3");
      err_clear = 1'b1;
      idle(1);
      err_clear = 1'b0;
      check_eq("t3_tmo_clr", 32'(err_timeout), 32'd0);

      // 4: overrun while holding
      strobe(8'h40);
      strobe(8'h99);
      expect_cmd("t4_hold", 8'h40, 32'h99);
      strobe(8'h03);
      check_eq("t4_ovr", 32'(err_overrun), 32'd1);
      expect_cmd("t4_kept", 8'h40, 32'h99);
      err_clear = 1'b1;
      rcv_full  = 1'b1;
      rcv_data  = 8'h07;
      @(negedge clk);
      rcv_full  = 1'b0;
      err_clear = 1'b0;
      check_eq("t4_set_wins", 32'(err_overrun), 32'd1);
      err_clear = 1'b1;
      idle(1);
      err_clear = 1'b0;
      check_eq("t4_ovr_clr", 32'(err_overrun), 32'd0);
      check_eq("t4_tmo", 32'(err_timeout), 32'd0);

      // 5: retire and new opcode in the same cycle
      cmd_ready = 1'b1;
      rcv_full  = 1'b1;
      rcv_data  = 8'h00;
      @(negedge clk);
      rcv_full  = 1'b0;
      cmd_ready = 1'b0;
      expect_cmd("t5", 8'h00, 32'h0);
      check_eq("t5_ovr", 32'(err_overrun), 32'd0);
      cmd_ready = 1'b1;
      rcv_full  = 1'b1;
      rcv_data  = 8'h40;
      @(negedge clk);
      rcv_full  = 1'b0;
      cmd_ready = 1'b0;
      check_eq("t5_args_valid", 32'(cmd_valid), 32'd0);
      check_eq("t5_args_op", 32'(cmd_opcode), 32'h40);
      strobe(8'hAB);
      expect_cmd("t5b", 8'h40, 32'hAB);
      retire("t5b");

      // 6: asynchronous reset mid-packet
      strobe(8'hC0);
      strobe(8'h11);
      check_eq("t6_pre_op", 32'(cmd_opcode), 32'hC0);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_rst_valid", 32'(cmd_valid), 32'd0);
      check_eq("t6_rst_opcode", 32'(cmd_opcode), 32'd0);
      check_eq("t6_rst_arg", cmd_arg, 32'd0);
      check_eq("t6_rst_tmo", 32'(err_timeout), 32'd0);
      check_eq("t6_rst_ovr", 32'(err_overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      strobe(8'h01);
      expect_cmd("t6_after", 8'h01, 32'h0);
      retire("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
